// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and result-flag layout for the ALU op sequencer.
package alu_seq_pkg;

   localparam logic [3:0] OP_NOP       = 4'd0;
   localparam logic [3:0] OP_ADD       = 4'd1;
   localparam logic [3:0] OP_ADD_CARRY = 4'd2;
   localparam logic [3:0] OP_SUB       = 4'd3;
   localparam logic [3:0] OP_INC       = 4'd4;
   localparam logic [3:0] OP_DEC       = 4'd5;
   localparam logic [3:0] OP_AND       = 4'd6;
   localparam logic [3:0] OP_NOT       = 4'd7;
   localparam logic [3:0] OP_ROL       = 4'd8;
   localparam logic [3:0] OP_ROR       = 4'd9;
   localparam logic [3:0] OP_LOAD      = 4'hF;

   localparam int unsigned NUM_FLAGS    = 5;
   localparam int unsigned FLAG_CARRY   = 0;
   localparam int unsigned FLAG_BORROW  = 1;
   localparam int unsigned FLAG_ZERO    = 2;
   localparam int unsigned FLAG_PARITY  = 3;
   localparam int unsigned FLAG_INVALID = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } state_e;

   function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic invalid, input logic parity,
                                                       input logic zero, input logic borrow,
                                                       input logic carry);
      logic [NUM_FLAGS-1:0] f;
      f               = '0;
      f[FLAG_INVALID] = invalid;
      f[FLAG_PARITY]  = parity;
      f[FLAG_ZERO]    = zero;
      f[FLAG_BORROW]  = borrow;
      f[FLAG_CARRY]   = carry;
      return f;
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the sequencer: two asynchronous read ports, one synchronous write port,
// cleared by the asynchronous reset.
module alu_seq_regfile #(
   parameter int unsigned BUS_WIDTH = 8,
   parameter int unsigned NUM_REGS  = 4,
   parameter int unsigned REG_AW    = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [REG_AW-1:0]    waddr,
   input  logic [BUS_WIDTH-1:0] wdata,
   input  logic [REG_AW-1:0]    raddr_a,
   output logic [BUS_WIDTH-1:0] rdata_a,
   input  logic [REG_AW-1:0]    raddr_b,
   output logic [BUS_WIDTH-1:0] rdata_b
);

   logic [BUS_WIDTH-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else if (we) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata_a = regs_q[raddr_a];
   assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives one external combinational ALU from a serial instruction stream: IDLE accepts,
// EXEC runs the ALU (or a LOAD) for one cycle and writes back, RESP holds the result.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter  int unsigned BUS_WIDTH = 8,
   parameter  int unsigned NUM_REGS  = 4,
   localparam int unsigned REG_AW    = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [3:0]           instr_opcode,
   input  logic [REG_AW-1:0]    instr_dst,
   input  logic [REG_AW-1:0]    instr_src_a,
   input  logic [REG_AW-1:0]    instr_src_b,
   input  logic [BUS_WIDTH-1:0] instr_imm,
   output logic [3:0]           alu_opcode,
   output logic [BUS_WIDTH-1:0] alu_a,
   output logic [BUS_WIDTH-1:0] alu_b,
   output logic                 alu_carry_in,
   input  logic [BUS_WIDTH-1:0] alu_y,
   input  logic                 alu_carry_out,
   input  logic                 alu_borrow,
   input  logic                 alu_zero,
   input  logic                 alu_parity,
   input  logic                 alu_invalid_op,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [BUS_WIDTH-1:0] res_data,
   output logic [NUM_FLAGS-1:0] res_flags,
   output logic [15:0]          done_count
);

   state_e               state_q, state_d;
   logic [3:0]           op_q;
   logic [REG_AW-1:0]    dst_q, src_a_q, src_b_q;
   logic [BUS_WIDTH-1:0] imm_q;
   logic                 latch_en;
   logic                 c_q, c_d;
   logic [BUS_WIDTH-1:0] res_data_q, res_data_d;
   logic [NUM_FLAGS-1:0] res_flags_q, res_flags_d;
   logic [15:0]          done_count_q, done_count_d;

   logic                 rf_we;
   logic [BUS_WIDTH-1:0] rf_wdata;
   logic [BUS_WIDTH-1:0] rd_a, rd_b;

   alu_seq_regfile #(
      .BUS_WIDTH (BUS_WIDTH),
      .NUM_REGS  (NUM_REGS),
      .REG_AW    (REG_AW)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (rf_we),
      .waddr   (dst_q),
      .wdata   (rf_wdata),
      .raddr_a (src_a_q),
      .rdata_a (rd_a),
      .raddr_b (src_b_q),
      .rdata_b (rd_b)
   );

   always_comb begin
      state_d      = state_q;
      instr_ready  = 1'b0;
      res_valid    = 1'b0;
      latch_en     = 1'b0;
      alu_opcode   = OP_NOP;
      alu_a        = '0;
      alu_b        = '0;
      rf_we        = 1'b0;
      rf_wdata     = '0;
      c_d          = c_q;
      res_data_d   = res_data_q;
      res_flags_d  = res_flags_q;
      done_count_d = done_count_q;

      unique case (state_q)
         StIdle: begin
            instr_ready = ~rst;
            if (instr_valid && instr_ready) begin
               latch_en = 1'b1;
               state_d  = StExec;
            end
         end
         StExec: begin
            state_d = StResp;
            if (op_q == OP_LOAD) begin
               // LOAD bypasses the ALU entirely; flags are derived locally from the immediate.
               rf_we       = 1'b1;
               rf_wdata    = imm_q;
               res_data_d  = imm_q;
               res_flags_d = pack_flags(1'b0, ^imm_q, imm_q == '0, 1'b0, 1'b0);
            end else begin
               alu_opcode = op_q;
               alu_a      = rd_a;
               alu_b      = rd_b;
               if (!alu_invalid_op) begin
                  rf_we       = 1'b1;
                  rf_wdata    = alu_y;
                  res_data_d  = alu_y;
                  res_flags_d = pack_flags(1'b0, alu_parity, alu_zero, alu_borrow,
                                           alu_carry_out);
                  case (op_q)
                     OP_ADD, OP_ADD_CARRY, OP_INC: c_d = alu_carry_out;
                     OP_SUB, OP_DEC:               c_d = alu_borrow;
                     default:                      c_d = c_q;
                  endcase
               end else begin
                  res_data_d  = '0;
                  res_flags_d = pack_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
               end
            end
         end
         StResp: begin
            res_valid = 1'b1;
            if (res_ready) begin
               done_count_d = done_count_q + 16'd1;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         op_q         <= OP_NOP;
         dst_q        <= '0;
         src_a_q      <= '0;
         src_b_q      <= '0;
         imm_q        <= '0;
         c_q          <= 1'b0;
         res_data_q   <= '0;
         res_flags_q  <= '0;
         done_count_q <= '0;
      end else begin
         state_q      <= state_d;
         c_q          <= c_d;
         res_data_q   <= res_data_d;
         res_flags_q  <= res_flags_d;
         done_count_q <= done_count_d;
         if (latch_en) begin
            op_q    <= instr_opcode;
            dst_q   <= instr_dst;
            src_a_q <= instr_src_a;
            src_b_q <= instr_src_b;
            imm_q   <= instr_imm;
         end
      end
   end

   assign alu_carry_in = c_q;
   assign res_data     = res_data_q;
   assign res_flags    = res_flags_q;
   assign done_count   = done_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural stand-in for the external ALU.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  instr_opcode;
   logic [1:0]  instr_dst, instr_src_a, instr_src_b;
   logic [7:0]  instr_imm;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_a, alu_b;
   logic        alu_carry_in;
   logic [7:0]  alu_y;
   logic        alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic [4:0]  res_flags;
   logic [15:0] done_count;

   int checks   = 0;
   int failures = 0;
   int exp_done = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(
      .BUS_WIDTH (8),
      .NUM_REGS  (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_opcode   (instr_opcode),
      .instr_dst      (instr_dst),
      .instr_src_a    (instr_src_a),
      .instr_src_b    (instr_src_b),
      .instr_imm      (instr_imm),
      .alu_opcode     (alu_opcode),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_carry_in   (alu_carry_in),
      .alu_y          (alu_y),
      .alu_carry_out  (alu_carry_out),
      .alu_borrow     (alu_borrow),
      .alu_zero       (alu_zero),
      .alu_parity     (alu_parity),
      .alu_invalid_op (alu_invalid_op),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_data       (res_data),
      .res_flags      (res_flags),
      .done_count     (done_count)
   );

   // External ALU stand-in
   logic [8:0] m_sum;
   always_comb begin
      m_sum          = '0;
      alu_y          = '0;
      alu_carry_out  = 1'b0;
      alu_borrow     = 1'b0;
      alu_invalid_op = 1'b0;
      case (alu_opcode)
         4'd1: begin m_sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = m_sum[7:0];
                     alu_carry_out = m_sum[8]; end
         4'd2: begin m_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
                     alu_y = m_sum[7:0]; alu_carry_out = m_sum[8]; end
         4'd3: begin alu_y = alu_a - alu_b; alu_borrow = alu_a < alu_b; end
         4'd4: begin m_sum = {1'b0, alu_a} + 9'd1; alu_y = m_sum[7:0];
                     alu_carry_out = m_sum[8]; end
         4'd5: begin alu_y = alu_a - 8'd1; alu_borrow = alu_a == 8'd0; end
         4'd6: alu_y = alu_a & alu_b;
         4'd7: alu_y = ~alu_a;
         4'd8: alu_y = {alu_a[6:0], alu_a[7]};
         4'd9: alu_y = {alu_a[0], alu_a[7:1]};
         default: alu_invalid_op = 1'b1;
      endcase
      alu_zero   = alu_y == 8'd0;
      alu_parity = ^alu_y;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Issue one instruction, check EXEC-cycle ALU drive, latency, result, hold, handshake.
   task automatic do_instr(input string tag, input logic [3:0] op, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb, input logic [7:0] imm,
                           input logic [7:0] exp_data, input logic [4:0] exp_flags,
                           input logic exp_cin, input int hold);
      int cycles;
      @(negedge clk);
      instr_opcode = op;
      instr_dst    = dst;
      instr_src_a  = sa;
      instr_src_b  = sb;
      instr_imm    = imm;
      instr_valid  = 1'b1;
      chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
      instr_valid = 1'b0;
      chk({tag, "_cin"}, {31'd0, alu_carry_in}, {31'd0, exp_cin});
      chk({tag, "_aluop"}, {28'd0, alu_opcode}, (op == 4'hF) ? 32'd0 : {28'd0, op});
      cycles = 1;
      while (!res_valid && cycles < 6) begin
         @(negedge clk);
         cycles++;
      end
      chk({tag, "_latency"}, cycles, 32'd2);
      chk({tag, "_data"}, {24'd0, res_data}, {24'd0, exp_data});
      chk({tag, "_flags"}, {27'd0, res_flags}, {27'd0, exp_flags});
      for (int i = 0; i < hold; i++) begin
         instr_valid = 1'b1;
         @(negedge clk);
         chk({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
         chk({tag, "_hold_data"}, {24'd0, res_data}, {24'd0, exp_data});
         chk({tag, "_hold_flags"}, {27'd0, res_flags}, {27'd0, exp_flags});
         chk({tag, "_hold_ready"}, {31'd0, instr_ready}, 32'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready   = 1'b0;
      instr_valid = 1'b0;
      exp_done++;
      chk({tag, "_done"}, {16'd0, done_count}, exp_done);
      chk({tag, "_idle_ready"}, {31'd0, instr_ready}, 32'd1);
      chk({tag, "_idle_valid"}, {31'd0, res_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      instr_valid  = 1'b0;
      res_ready    = 1'b0;
      instr_opcode = '0;
      instr_dst    = '0;
      instr_src_a  = '0;
      instr_src_b  = '0;
      instr_imm    = '0;
      repeat (2) @(negedge clk);
      chk("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_res_data", {24'd0, res_data}, 32'd0);
      chk("rst_res_flags", {27'd0, res_flags}, 32'd0);
      chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
      chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
      chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
      chk("rst_cin", {31'd0, alu_carry_in}, 32'd0);
      chk("rst_done", {16'd0, done_count}, 32'd0);
      rst = 1'b0;

      // Basic add
      do_instr("ld_r0_9",   4'hF, 2'd0, 2'd0, 2'd0, 8'd9,   8'd9,   5'b00000, 1'b0, 0);
      do_instr("ld_r1_33",  4'hF, 2'd1, 2'd0, 2'd0, 8'd33,  8'd33,  5'b00000, 1'b0, 0);
      do_instr("add_42",    4'd1, 2'd2, 2'd0, 2'd1, 8'd0,   8'd42,  5'b01000, 1'b0, 0);
      do_instr("rd_r2_42",  4'd6, 2'd2, 2'd2, 2'd2, 8'd0,   8'd42,  5'b01000, 1'b0, 0);

      // Carry out then add-with-carry
      do_instr("ld_r0_200", 4'hF, 2'd0, 2'd0, 2'd0, 8'd200, 8'd200, 5'b01000, 1'b0, 0);
      do_instr("ld_r1_100", 4'hF, 2'd1, 2'd0, 2'd0, 8'd100, 8'd100, 5'b01000, 1'b0, 0);
      do_instr("add_44c",   4'd1, 2'd2, 2'd0, 2'd1, 8'd0,   8'd44,  5'b01001, 1'b0, 0);
      do_instr("adc_89",    4'd2, 2'd3, 2'd2, 2'd2, 8'd0,   8'd89,  5'b00000, 1'b1, 0);

      // Subtract with and without borrow
      do_instr("ld_r0_65",  4'hF, 2'd0, 2'd0, 2'd0, 8'd65,  8'd65,  5'b00000, 1'b0, 0);
      do_instr("ld_r1_66",  4'hF, 2'd1, 2'd0, 2'd0, 8'd66,  8'd66,  5'b00000, 1'b0, 0);
      do_instr("sub_255",   4'd3, 2'd2, 2'd0, 2'd1, 8'd0,   8'd255, 5'b00010, 1'b0, 0);
      do_instr("sub_1",     4'd3, 2'd3, 2'd1, 2'd0, 8'd0,   8'd1,   5'b01000, 1'b1, 0);

      // Invalid opcode: no writeback, C untouched
      do_instr("ld_r2_7",   4'hF, 2'd2, 2'd0, 2'd0, 8'd7,   8'd7,   5'b01000, 1'b0, 0);
      do_instr("inv_op12",  4'd12, 2'd2, 2'd0, 2'd1, 8'd0,  8'd0,   5'b10000, 1'b0, 0);
      do_instr("rd_r2_7",   4'd6, 2'd2, 2'd2, 2'd2, 8'd0,   8'd7,   5'b01000, 1'b0, 0);

      // Backpressure: result held 5 cycles while another instruction waits
      do_instr("add_hold",  4'd1, 2'd3, 2'd2, 2'd2, 8'd0,   8'd14,  5'b01000, 1'b0, 5);

      // Set C=1 so the reset below must clear it
      do_instr("sub_setc",  4'd3, 2'd2, 2'd0, 2'd1, 8'd0,   8'd255, 5'b00010, 1'b0, 0);

      // Reset during EXEC of ADD r2 = r0 + r1
      @(negedge clk);
      instr_opcode = 4'd1;
      instr_dst    = 2'd2;
      instr_src_a  = 2'd0;
      instr_src_b  = 2'd1;
      instr_valid  = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("mid_exec_op", {28'd0, alu_opcode}, 32'd1);
      chk("mid_exec_cin", {31'd0, alu_carry_in}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_instr_ready", {31'd0, instr_ready}, 32'd0);
      chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("mid_rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
      chk("mid_rst_cin", {31'd0, alu_carry_in}, 32'd0);
      chk("mid_rst_res_data", {24'd0, res_data}, 32'd0);
      chk("mid_rst_done", {16'd0, done_count}, 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      exp_done = 0;
      do_instr("post_rd_r2", 4'd6, 2'd2, 2'd2, 2'd2, 8'd0, 8'd0, 5'b00100, 1'b0, 0);
      do_instr("post_rd_r1", 4'd6, 2'd1, 2'd1, 2'd1, 8'd0, 8'd0, 5'b00100, 1'b0, 0);
      do_instr("post_ld_5",  4'hF, 2'd0, 2'd0, 2'd0, 8'd5, 8'd5, 5'b00000, 1'b0, 0);
      do_instr("post_rd_r0", 4'd6, 2'd0, 2'd0, 2'd0, 8'd0, 8'd5, 5'b00000, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequences the shared combinational ALU for a stream of register-to-register instructions.
- Holds a small register file and a sticky carry flag; drives the ALU opcode, operands and carry_in; captures y and flags; writes the result back.
- Reports each completed instruction on a valid/ready result port.
- Sits between an instruction source (test sequencer or small controller) and one external ALU instance.

Parameters:
- BUS_WIDTH, 8, data width of registers, ALU operands and result.
- NUM_REGS, 4, register-file depth; power of two, minimum 2.
- REG_AW, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_opcode  in  4  ALU opcode 1..9, or 4'hF = LOAD.
- instr_dst  in  REG_AW  destination register.
- instr_src_a  in  REG_AW  operand A register; also the operand for unary ops.
- instr_src_b  in  REG_AW  operand B register.
- instr_imm  in  BUS_WIDTH  immediate, used only by LOAD.
- alu_opcode  out  4  to ALU opcode.
- alu_a, alu_b  out  BUS_WIDTH  to ALU operands.
- alu_carry_in  out  1  to ALU carry_in; equals the sticky carry flag C.
- alu_y  in  BUS_WIDTH  from ALU.
- alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op  in  1 each  from ALU.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  BUS_WIDTH  result value.
- res_flags  out  5  {invalid, parity, zero, borrow, carry}, bit 4 down to bit 0.
- done_count  out  16  completed instructions; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async, asserted):
  - State IDLE; all registers 0; C = 0; done_count 0.
  - res_valid 0, res_data 0, res_flags 0.
  - alu_opcode 0, alu_a 0, alu_b 0, alu_carry_in 0.
  - instr_ready 0 while rst is high.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch opcode/dst/src_a/src_b/imm and go to EXEC.
- EXEC (exactly one cycle):
  - ALU ops: alu_opcode = latched opcode, alu_a = R[src_a], alu_b = R[src_b]. All ALU outputs are sampled at the end of this cycle.
  - Outside EXEC, alu_opcode = 0 and alu_a / alu_b are held at 0.
  - Valid op (alu_invalid_op = 0): R[dst] <= alu_y; res_data <= alu_y; res_flags <= ALU flags.
  - C update: ops 1, 2 and 4 load alu_carry_out; ops 3 and 5 load alu_borrow; ops 6–9 leave C unchanged.
  - Invalid op (opcode 0 or 10–14, i.e. alu_invalid_op = 1): no writeback; C unchanged; res_data <= 0; res_flags <= 5'b10000.
  - LOAD (4'hF): ALU is not used (alu_opcode stays 0). R[dst] <= imm; res_data <= imm; flags are carry 0, borrow 0, zero = (imm == 0), parity = ^imm, invalid 0. C unchanged.
  - Always go to RESP.
- RESP:
  - res_valid = 1; res_data and res_flags stay stable until res_ready.
  - On res_ready: done_count++ (invalid ops included), then go to IDLE.
  - instr_ready = 0 throughout RESP.
- Latency: instruction accepted in cycle N, res_valid high in cycle N+2. Maximum throughput is 1 instruction per 3 cycles.
- dst == src_a or dst == src_b is legal: operands are read before the EXEC-end write.
- Instructions are strictly serial, so there are no data hazards.
- instr_valid may drop without being accepted; nothing is latched in that case.
- Reset asserted mid-EXEC or mid-RESP: the in-flight instruction is discarded and no partial writeback occurs.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_NOP = 0, OP_ADD = 1, OP_ADD_CARRY = 2, OP_SUB = 3, OP_INC = 4, OP_DEC = 5, OP_AND = 6, OP_NOT = 7, OP_ROL = 8, OP_ROR = 9, OP_LOAD = 4'hF;
  - the FSM state encoding;
  - res_flags bit indices.
- One sub-module, alu_seq_regfile: NUM_REGS x BUS_WIDTH, two async read ports, one sync write port, async-reset clear.

Test Plan:
- LOAD r0 = 9, LOAD r1 = 33, ADD r2 = r0 + r1 -> res_data 42, carry 0, zero 0; r2 = 42; each res_valid appears exactly 2 cycles after acceptance.
- LOAD r0 = 200, LOAD r1 = 100, ADD r2 = r0 + r1 -> res_data 44, carry 1, C = 1; then ADD_CARRY r3 = r2 + r2 -> alu_carry_in 1, res_data 89, C = 0.
- LOAD r0 = 65, r1 = 66; SUB r2 = r0 - r1 -> res_data 255, borrow 1, C = 1; then SUB r3 = r1 - r0 -> res_data 1, borrow 0, C = 0.
- Opcode 12 with dst r2 (r2 = 7) -> res_flags 5'b10000, res_data 0, r2 still 7, done_count increments.
- Hold res_ready = 0 for 5 cycles after an ADD -> res_valid, res_data and res_flags stable; instr_ready 0; a second instr_valid is not accepted until the cycle after the handshake.
- Assert rst during EXEC of ADD r2 = r0 + r1 -> immediate IDLE, all registers 0, res_valid 0, C = 0; a following LOAD r0 = 5 completes normally with res_data 5.
